// File: rtl/slv_guard.sv
// slv_guard: AXI4 pass-through with handshake latency watchdog.
// Sticky per-phase faults drive irq_o and rst_req_o.
package slv_guard_pkg;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [0:0]  user;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
  } axi_w_t;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        write;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module slv_guard #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned StrbWidth    = DataWidth / 8,
  parameter int unsigned AxiIdWidth   = 2,
  parameter int unsigned AxiUserWidth = 1,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned MaxWrUniqIds = 4,
  parameter int unsigned MaxRdUniqIds = 4,
  parameter int unsigned MaxWrTxns    = 8,
  parameter int unsigned MaxRdTxns    = 4,
  parameter int unsigned CntWidth     = 32,
  parameter int unsigned IntIdWidth   = 2,
  parameter type req_t     = slv_guard_pkg::axi_req_t,
  parameter type rsp_t     = slv_guard_pkg::axi_rsp_t,
  parameter type slv_req_t = slv_guard_pkg::axi_req_t,
  parameter type slv_rsp_t = slv_guard_pkg::axi_rsp_t,
  parameter type reg_req_t = slv_guard_pkg::reg_req_t,
  parameter type reg_rsp_t = slv_guard_pkg::reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     guard_ena_i,
  input  req_t     req_i,
  output rsp_t     rsp_o,
  output req_t     req_o,
  input  rsp_t     rsp_i,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output logic     irq_o,
  output logic     rst_req_o
);

  localparam int unsigned NumChk = 10;
  localparam int unsigned WrW = $clog2(MaxWrTxns + 1);
  localparam int unsigned RdW = $clog2(MaxRdTxns + 1);
  localparam logic [WrW-1:0] WrMax = WrW'(MaxWrTxns);
  localparam logic [RdW-1:0] RdMax = RdW'(MaxRdTxns);
  localparam logic [WrW-1:0] WrOne = WrW'(1);
  localparam logic [RdW-1:0] RdOne = RdW'(1);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  if (StrbWidth != DataWidth / 8 || AxiIdWidth == 0 ||
      AxiUserWidth == 0 || MaxTxnsPerId == 0 ||
      MaxWrUniqIds == 0 || MaxRdUniqIds == 0 ||
      IntIdWidth == 0 || MaxWrTxns == 0 || MaxRdTxns == 0 ||
      CntWidth == 0 || CntWidth > 32 || AddrWidth < 7 ||
      AddrWidth > 32 || $bits(slv_req_t) == 0 ||
      $bits(slv_rsp_t) == 0) begin : g_bad_param
    $error("slv_guard: unsupported parameters");
  end

  assign req_o = req_i;
  assign rsp_o = rsp_i;

  logic aw_hs, w_hs, wl_hs, b_hs, ar_hs, r_hs, rl_hs;
  assign aw_hs = req_i.aw_valid & rsp_i.aw_ready;
  assign w_hs  = req_i.w_valid & rsp_i.w_ready;
  assign wl_hs = w_hs & req_i.w.last;
  assign b_hs  = rsp_i.b_valid & req_i.b_ready;
  assign ar_hs = req_i.ar_valid & rsp_i.ar_ready;
  assign r_hs  = rsp_i.r_valid & req_i.r_ready;
  assign rl_hs = r_hs & rsp_i.r.last;

  logic [WrW-1:0] aw_wait_q, aw_wait_d;
  logic [WrW-1:0] wr_done_q, wr_done_d;
  logic [RdW-1:0] rd_out_q, rd_out_d;
  logic           w_burst_q, w_burst_d;
  logic           r_burst_q, r_burst_d;

  logic                ctrl_q, ctrl_d;
  logic [31:0]         bud_q [NumChk];
  logic [31:0]         bud_d [NumChk];
  logic [CntWidth-1:0] cnt_q [NumChk];
  logic [CntWidth-1:0] cnt_d [NumChk];
  logic [NumChk-1:0]   status_q, status_d;
  logic                irq_q, irq_d;

  logic [NumChk-1:0] act;
  logic [NumChk-1:0] set;
  logic [NumChk-1:0] w1c;
  logic              active;
  logic [3:0]        idx;
  logic              hit;
  logic              we;
  logic [31:0]       rdata;

  // Outstanding-transaction bookkeeping, saturating both ways.
  always_comb begin
    aw_wait_d = aw_wait_q;
    wr_done_d = wr_done_q;
    rd_out_d  = rd_out_q;
    w_burst_d = w_burst_q;
    r_burst_d = r_burst_q;
    if (aw_hs && !wl_hs && aw_wait_q != WrMax) begin
      aw_wait_d = aw_wait_q + WrOne;
    end else if (!aw_hs && wl_hs && aw_wait_q != '0) begin
      aw_wait_d = aw_wait_q - WrOne;
    end
    if (wl_hs && !b_hs && wr_done_q != WrMax) begin
      wr_done_d = wr_done_q + WrOne;
    end else if (!wl_hs && b_hs && wr_done_q != '0) begin
      wr_done_d = wr_done_q - WrOne;
    end
    if (ar_hs && !rl_hs && rd_out_q != RdMax) begin
      rd_out_d = rd_out_q + RdOne;
    end else if (!ar_hs && rl_hs && rd_out_q != '0) begin
      rd_out_d = rd_out_q - RdOne;
    end
    if (wl_hs) begin
      w_burst_d = 1'b0;
    end else if (w_hs) begin
      w_burst_d = 1'b1;
    end
    if (rl_hs) begin
      r_burst_d = 1'b0;
    end else if (r_hs) begin
      r_burst_d = 1'b1;
    end
  end

  // Phase-active terms; the ending handshake excludes its own cycle.
  always_comb begin
    act    = '0;
    act[0] = req_i.aw_valid & ~rsp_i.aw_ready;
    act[1] = (aw_wait_q != '0) & ~w_burst_q & ~w_hs;
    act[2] = req_i.w_valid & ~rsp_i.w_ready;
    act[3] = w_burst_q & ~wl_hs;
    act[4] = (wr_done_q != '0) & ~rsp_i.b_valid;
    act[5] = rsp_i.b_valid & ~req_i.b_ready;
    act[6] = req_i.ar_valid & ~rsp_i.ar_ready;
    act[7] = (rd_out_q != '0) & ~r_burst_q & ~r_hs;
    act[8] = rsp_i.r_valid & ~req_i.r_ready;
    act[9] = r_burst_q & ~rl_hs;
  end

  assign active = guard_ena_i & ctrl_q;

  // Phase counters and budget compare raising fault set pulses.
  always_comb begin
    set = '0;
    for (int i = 0; i < NumChk; i++) begin
      cnt_d[i] = '0;
      if (active && act[i]) begin
        cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CntOne;
        set[i]   = (bud_q[i] != '0) && (32'(cnt_d[i]) == bud_q[i]);
      end
    end
  end

  assign idx = reg_req_i.addr[5:2];
  assign hit = (reg_req_i.addr[1:0] == 2'b00) &&
               (reg_req_i.addr[AddrWidth-1:6] == '0) &&
               (idx <= 4'd11);
  assign we  = reg_req_i.valid & reg_req_i.write & hit;

  // Register writes with byte strobes; STATUS is set-wins W1C.
  always_comb begin
    ctrl_d = ctrl_q;
    w1c    = '0;
    for (int i = 0; i < NumChk; i++) begin
      bud_d[i] = bud_q[i];
      if (we && idx == 4'(i + 1)) begin
        for (int b = 0; b < 4; b++) begin
          if (reg_req_i.wstrb[b]) begin
            bud_d[i][8*b+:8] = reg_req_i.wdata[8*b+:8];
          end
        end
      end
    end
    if (we && idx == 4'd0 && reg_req_i.wstrb[0]) begin
      ctrl_d = reg_req_i.wdata[0];
    end
    if (we && idx == 4'd11) begin
      w1c = {reg_req_i.wdata[9:8] & {2{reg_req_i.wstrb[1]}},
             reg_req_i.wdata[7:0] & {8{reg_req_i.wstrb[0]}}};
    end
    status_d = (status_q & ~w1c) | set;
    irq_d    = |status_q;
  end

  // Register read mux and zero-wait response.
  always_comb begin
    rdata = '0;
    if (hit) begin
      if (idx == 4'd0) rdata = {31'b0, ctrl_q};
      if (idx == 4'd11) rdata = {22'b0, status_q};
      for (int i = 0; i < NumChk; i++) begin
        if (idx == 4'(i + 1)) rdata = bud_q[i];
      end
    end
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    reg_rsp_o.error = reg_req_i.valid & ~hit;
    reg_rsp_o.rdata = reg_req_i.valid ? rdata : '0;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_wait_q <= '0;
      wr_done_q <= '0;
      rd_out_q  <= '0;
      w_burst_q <= 1'b0;
      r_burst_q <= 1'b0;
      ctrl_q    <= 1'b0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NumChk; i++) begin
        bud_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      aw_wait_q <= aw_wait_d;
      wr_done_q <= wr_done_d;
      rd_out_q  <= rd_out_d;
      w_burst_q <= w_burst_d;
      r_burst_q <= r_burst_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
      for (int i = 0; i < NumChk; i++) begin
        bud_q[i] <= bud_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign irq_o     = irq_q;
  assign rst_req_o = irq_q;

endmodule

// File: tb/tb_slv_guard.sv
// tb_slv_guard: directed and randomized checks of slv_guard.
// Expected faults come from phase lengths versus budgets.
module tb_slv_guard;
  import slv_guard_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     ena = 1'b1;
  axi_req_t m_req, s_req;
  axi_rsp_t s_rsp, m_rsp;
  reg_req_t rq;
  reg_rsp_t rs;
  logic     irq, rst_req;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  slv_guard dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .guard_ena_i (ena),
    .req_i       (m_req),
    .rsp_o       (m_rsp),
    .req_o       (s_req),
    .rsp_i       (s_rsp),
    .reg_req_i   (rq),
    .reg_rsp_o   (rs),
    .irq_o       (irq),
    .rst_req_o   (rst_req)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] s);
    rq.addr  = a;
    rq.wdata = d;
    rq.wstrb = s;
    rq.write = 1'b1;
    rq.valid = 1'b1;
    step();
    rq.valid = 1'b0;
    rq.write = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a,
                        output logic [31:0] d,
                        output logic e);
    rq.addr  = a;
    rq.write = 1'b0;
    rq.valid = 1'b1;
    #1;
    d = rs.rdata;
    e = rs.error;
    rq.valid = 1'b0;
  endtask

  task automatic do_write(input int aws, input int wg,
                          input int nb, input int bg,
                          input int bs);
    m_req.aw_valid = 1'b1;
    s_rsp.aw_ready = 1'b0;
    repeat (aws) step();
    s_rsp.aw_ready = 1'b1;
    step();
    m_req.aw_valid = 1'b0;
    s_rsp.aw_ready = 1'b0;
    repeat (wg) step();
    for (int i = 0; i < nb; i++) begin
      m_req.w_valid = 1'b1;
      s_rsp.w_ready = 1'b1;
      m_req.w.last  = (i == nb - 1);
      step();
    end
    m_req.w_valid = 1'b0;
    s_rsp.w_ready = 1'b0;
    m_req.w.last  = 1'b0;
    repeat (bg) step();
    s_rsp.b_valid = 1'b1;
    m_req.b_ready = 1'b0;
    repeat (bs) step();
    m_req.b_ready = 1'b1;
    step();
    s_rsp.b_valid = 1'b0;
    m_req.b_ready = 1'b0;
  endtask

  task automatic do_read(input int ars, input int rg,
                         input int nb);
    m_req.ar_valid = 1'b1;
    s_rsp.ar_ready = 1'b0;
    repeat (ars) step();
    s_rsp.ar_ready = 1'b1;
    step();
    m_req.ar_valid = 1'b0;
    s_rsp.ar_ready = 1'b0;
    repeat (rg) step();
    for (int i = 0; i < nb; i++) begin
      s_rsp.r_valid = 1'b1;
      m_req.r_ready = 1'b1;
      s_rsp.r.last  = (i == nb - 1);
      step();
    end
    s_rsp.r_valid = 1'b0;
    m_req.r_ready = 1'b0;
    s_rsp.r.last  = 1'b0;
  endtask

  function automatic logic flt(input int unsigned bud,
                               input int unsigned len);
    return (bud != 0) && (len >= bud);
  endfunction

  logic [31:0] d;
  logic        e;
  logic [31:0] mdl [12];
  int unsigned bud [10];
  int          aws, wg, bg, bs, ars, rg;
  logic [9:0]  mask;

  initial begin
    m_req = '0;
    s_rsp = '0;
    rq    = '0;
    repeat (2) step();
    rq.addr  = 32'h2C;
    rq.valid = 1'b1;
    #1;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_rstreq", 32'(rst_req), 0);
    chk("rst_ready", 32'(rs.ready), 1);
    chk("rst_status", rs.rdata, 0);
    rq.valid = 1'b0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      reg_rd(32'(i * 4), d, e);
      chk($sformatf("rst_reg%0d", i), d, 0);
      mdl[i] = '0;
      step();
    end
    reg_wr(32'h04, 32'h300, 4'hF);
    reg_rd(32'h04, d, e);
    chk("bud_rb", d, 32'h300);
    reg_rd(32'h30, d, e);
    chk("unmap_err", 32'(e), 1);
    chk("unmap_rdata", d, 0);
    reg_wr(32'h30, 32'hFFFF_FFFF, 4'hF);
    reg_rd(32'h2C, d, e);
    chk("unmap_nowr", d, 0);
    mdl[1] = 32'h300;

    repeat (8) begin
      int k;
      logic [31:0] v;
      logic [3:0]  s;
      k = int'($urandom_range(1, 10));
      v = $urandom;
      s = 4'($urandom_range(0, 15));
      reg_wr(32'(k * 4), v, s);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[k][8*b+:8] = v[8*b+:8];
      end
      reg_rd(32'(k * 4), d, e);
      chk($sformatf("strb_rb%0d", k), d, mdl[k]);
    end
    for (int k = 1; k <= 10; k++) begin
      reg_wr(32'(k * 4), 32'h0, 4'hF);
    end

    reg_wr(32'h00, 32'h1, 4'hF);
    reg_wr(32'h04, 32'd5, 4'hF);
    m_req.aw.addr  = 32'hA5A5_0000;
    m_req.aw_valid = 1'b1;
    s_rsp.aw_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      reg_rd(32'h2C, d, e);
      chk($sformatf("aw_stat_c%0d", k), 32'(d[0]),
          32'(k >= 5));
      chk($sformatf("aw_irq_c%0d", k), 32'(irq),
          32'(k >= 6));
      chk($sformatf("aw_rrq_c%0d", k), 32'(rst_req),
          32'(k >= 6));
      chk_w("aw_pass", 256'(s_req), 256'(m_req));
    end
    s_rsp.aw_ready = 1'b1;
    step();
    m_req.aw_valid = 1'b0;
    s_rsp.aw_ready = 1'b0;
    m_req.w_valid  = 1'b1;
    s_rsp.w_ready  = 1'b1;
    m_req.w.last   = 1'b1;
    step();
    m_req.w_valid  = 1'b0;
    s_rsp.w_ready  = 1'b0;
    m_req.w.last   = 1'b0;
    s_rsp.b_valid  = 1'b1;
    m_req.b_ready  = 1'b1;
    step();
    s_rsp.b_valid  = 1'b0;
    m_req.b_ready  = 1'b0;

    reg_wr(32'h2C, 32'h1, 4'hF);
    reg_rd(32'h2C, d, e);
    chk("w1c_status", d, 0);
    step();
    chk("w1c_irq", 32'(irq), 0);
    chk("w1c_rrq", 32'(rst_req), 0);

    reg_wr(32'h04, 32'h0, 4'hF);
    reg_wr(32'h20, 32'h1, 4'hF);
    do_read(0, 0, 2);
    reg_rd(32'h2C, d, e);
    chk("ar2r_lat1", d, 0);
    do_read(0, 1, 2);
    reg_rd(32'h2C, d, e);
    chk("ar2r_lat2", d, 32'h80);
    reg_wr(32'h2C, 32'h3FF, 4'hF);
    repeat (2) step();

    for (int it = 0; it < 20; it++) begin
      m_req.aw.addr = $urandom;
      m_req.w.data  = $urandom;
      s_rsp.r.data  = $urandom;
      s_rsp.b.resp  = 2'($urandom_range(0, 3));
      #1;
      chk_w("req_pass", 256'(s_req), 256'(m_req));
      chk_w("rsp_pass", 256'(m_rsp), 256'(s_rsp));
      for (int i = 0; i < 10; i++) bud[i] = 0;
      foreach (bud[i]) begin
        if (i != 2 && i != 3 && i != 8 && i != 9)
          bud[i] = $urandom_range(0, 5);
        reg_wr(32'((i + 1) * 4), bud[i], 4'hF);
      end
      aws = int'($urandom_range(0, 6));
      wg  = int'($urandom_range(0, 6));
      bg  = int'($urandom_range(0, 6));
      bs  = int'($urandom_range(0, 6));
      ars = int'($urandom_range(0, 6));
      rg  = int'($urandom_range(0, 6));
      mask    = '0;
      mask[0] = flt(bud[0], aws);
      mask[1] = flt(bud[1], wg);
      mask[4] = flt(bud[4], bg);
      mask[5] = flt(bud[5], bs);
      mask[6] = flt(bud[6], ars);
      mask[7] = flt(bud[7], rg);
      do_write(aws, wg, int'($urandom_range(1, 3)), bg, bs);
      do_read(ars, rg, int'($urandom_range(1, 3)));
      reg_rd(32'h2C, d, e);
      chk($sformatf("rnd_stat%0d", it), d, 32'(mask));
      step();
      chk($sformatf("rnd_irq%0d", it), 32'(irq),
          32'(mask != 0));
      reg_wr(32'h2C, 32'h3FF, 4'hF);
      step();
      chk($sformatf("rnd_clr%0d", it), 32'(irq), 0);
    end

    for (int k = 1; k <= 10; k++) begin
      reg_wr(32'(k * 4), 32'h300, 4'hF);
    end
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(int'($urandom_range(0, 8)),
                 int'($urandom_range(0, 8)),
                 int'($urandom_range(1, 4)),
                 int'($urandom_range(0, 8)),
                 int'($urandom_range(0, 8)));
      else
        do_read(int'($urandom_range(0, 8)),
                int'($urandom_range(0, 8)),
                int'($urandom_range(1, 4)));
    end
    reg_rd(32'h2C, d, e);
    chk("traffic_status", d, 0);
    chk("traffic_irq", 32'(irq), 0);

    for (int k = 1; k <= 10; k++) begin
      reg_wr(32'(k * 4), 32'h0, 4'hF);
    end
    reg_wr(32'h04, 32'd5, 4'hF);
    reg_wr(32'h00, 32'h100, 4'h1);
    reg_rd(32'h00, d, e);
    chk("ctrl_off", d, 0);
    do_write(100, 0, 1, 0, 0);
    reg_rd(32'h2C, d, e);
    chk("ctrl_off_nf", d, 0);
    reg_wr(32'h00, 32'h1, 4'hF);
    ena = 1'b0;
    do_write(100, 0, 1, 0, 0);
    reg_rd(32'h2C, d, e);
    chk("hw_off_nf", d, 0);
    step();
    chk("hw_off_irq", 32'(irq), 0);
    ena = 1'b1;
    do_write(10, 0, 1, 0, 0);
    reg_rd(32'h2C, d, e);
    chk("reenable_f", d, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
